// File: rtl/captura_de_datos.sv
// Byte-serial RGB565 camera capture: pairs bytes into pixels, converts to RGB332 and writes a linear frame buffer.
// Optional macro CAPTURA_FRAME_DONE_EN adds a one-cycle Frame_done pulse after the last pixel of a frame.
module captura_de_datos #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int AW     = 15
) (
  input  logic          Pclk,
  input  logic          Rst_n,
  input  logic          Href,
  input  logic          Vsync,
  input  logic [7:0]    D,
  output logic [AW-1:0] addr,
  output logic [7:0]    RGB332,
  output logic          write
`ifdef CAPTURA_FRAME_DONE_EN
  ,
  output logic          Frame_done
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);

  typedef enum logic {
    FIRST,
    SECOND
  } phase_t;

  phase_t        phase, phase_nxt;
  logic [7:0]    hold, hold_nxt;
  logic [7:0]    rgb_nxt;
  logic [AW-1:0] addr_nxt;
  logic          write_nxt;
  logic          full, full_nxt;
  logic          full_set;

  // The edge after the write to the last address freezes capture until the next Vsync.
  assign full_set = !Vsync && !full && write && (addr == LAST_ADDR);

  always_ff @(posedge Pclk or negedge Rst_n) begin
    if (!Rst_n) begin
      phase  <= FIRST;
      hold   <= '0;
      addr   <= '0;
      RGB332 <= '0;
      write  <= 1'b0;
      full   <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      hold   <= hold_nxt;
      addr   <= addr_nxt;
      RGB332 <= rgb_nxt;
      write  <= write_nxt;
      full   <= full_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    hold_nxt  = hold;
    rgb_nxt   = RGB332;
    addr_nxt  = addr;
    write_nxt = 1'b0;
    full_nxt  = full;

    if (Vsync) begin
      addr_nxt  = '0;
      phase_nxt = FIRST;
      full_nxt  = 1'b0;
    end else if (full) begin
      phase_nxt = FIRST;
    end else if (full_set) begin
      full_nxt  = 1'b1;
      phase_nxt = FIRST;
    end else begin
      // Address advances only after the write cycle so it equals the pixel index while write is high.
      if (write) begin
        addr_nxt = addr + AW'(1);
      end
      if (!Href) begin
        phase_nxt = FIRST;
      end else if (phase == FIRST) begin
        hold_nxt  = D;
        phase_nxt = SECOND;
      end else begin
        rgb_nxt   = {hold[7:5], hold[2:0], D[4:3]};
        write_nxt = 1'b1;
        phase_nxt = FIRST;
      end
    end
  end

`ifdef CAPTURA_FRAME_DONE_EN
  always_ff @(posedge Pclk or negedge Rst_n) begin
    if (!Rst_n) begin
      Frame_done <= 1'b0;
    end else begin
      Frame_done <= full_set;
    end
  end
`endif

endmodule

// File: tb/tb_captura_de_datos.sv
// Randomized bench for captura_de_datos against a pixel-counting reference model.
// Frame_done is checked only when CAPTURA_FRAME_DONE_EN is defined.
module tb_captura_de_datos;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int AW     = 15;
  localparam int TOTAL  = WIDTH * HEIGHT;

  logic          Pclk;
  logic          Rst_n;
  logic          Href;
  logic          Vsync;
  logic [7:0]    D;
  logic [AW-1:0] addr;
  logic [7:0]    RGB332;
  logic          write;
`ifdef CAPTURA_FRAME_DONE_EN
  logic          Frame_done;
`endif

  captura_de_datos #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .AW    (AW)
  ) dut (
    .Pclk  (Pclk),
    .Rst_n (Rst_n),
    .Href  (Href),
    .Vsync (Vsync),
    .D     (D),
    .addr  (addr),
    .RGB332(RGB332),
    .write (write)
`ifdef CAPTURA_FRAME_DONE_EN
    ,
    .Frame_done(Frame_done)
`endif
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: counts pixels completed in the current frame.
  int   pixels;
  bit   have_first;
  int   first_byte;
  int   exp_rgb;
  bit   exp_wr;
  bit   exp_done;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int expAddr();
    if (exp_wr) return pixels - 1;
    if (pixels >= TOTAL) return TOTAL - 1;
    return pixels;
  endfunction

  task automatic modelReset();
    pixels     = 0;
    have_first = 1'b0;
    first_byte = 0;
    exp_rgb    = 0;
    exp_wr     = 1'b0;
    exp_done   = 1'b0;
  endtask

  task automatic modelStep(input bit h, input bit v, input int d);
    exp_done = 1'b0;
    if (v) begin
      pixels     = 0;
      have_first = 1'b0;
      exp_wr     = 1'b0;
    end else if (pixels >= TOTAL) begin
      exp_done   = exp_wr;
      exp_wr     = 1'b0;
      have_first = 1'b0;
    end else if (h) begin
      if (!have_first) begin
        first_byte = d;
        have_first = 1'b1;
        exp_wr     = 1'b0;
      end else begin
        exp_rgb    = (first_byte / 32) * 32 + (first_byte % 8) * 4 + ((d % 32) / 8);
        exp_wr     = 1'b1;
        pixels     = pixels + 1;
        have_first = 1'b0;
      end
    end else begin
      have_first = 1'b0;
      exp_wr     = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("write", 32'(write), 32'(exp_wr));
    checkOutput("addr", 32'(addr), 32'(expAddr()));
    checkOutput("rgb332", 32'(RGB332), 32'(exp_rgb));
`ifdef CAPTURA_FRAME_DONE_EN
    checkOutput("frame_done", 32'(Frame_done), 32'(exp_done));
`endif
  endtask

  // Drives one edge's inputs, lets the DUT sample them, then checks on the falling edge.
  task automatic applyStimulus(input bit h, input bit v, input logic [7:0] d);
    Href  = h;
    Vsync = v;
    D     = d;
    @(posedge Pclk);
    modelStep(h, v, int'(d));
    @(negedge Pclk);
    checkAll();
  endtask

  task automatic applyReset(input int cycles);
    Rst_n = 1'b0;
    Href  = 1'($urandom);
    D     = 8'($urandom);
    #1;
    modelReset();
    checkAll();
    for (int i = 0; i < cycles; i++) begin
      Href = 1'($urandom);
      D    = 8'($urandom);
      @(posedge Pclk);
      @(negedge Pclk);
      checkAll();
    end
    Rst_n = 1'b1;
  endtask

  task automatic sendLine(input int edges, input logic [7:0] d);
    for (int i = 0; i < edges; i++) applyStimulus(1'b1, 1'b0, d);
  endtask

  task automatic idle(input int edges);
    for (int i = 0; i < edges; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    Rst_n = 1'b0;
    Href  = 1'b0;
    Vsync = 1'b0;
    D     = 8'h00;
    modelReset();
    @(negedge Pclk);
    applyReset(4);

    // Conversion of 0x57,0x57 gives 0x5E at address 0.
    applyStimulus(1'b0, 1'b1, 8'h00);
    sendLine(2, 8'h57);
    checkOutput("conv_rgb", 32'(RGB332), 32'h5E);
    idle(2);

    // Two full lines continue addressing across the Href gap.
    sendLine(10, 8'h57);
    idle(5);
    sendLine(10, 8'h57);
    idle(3);

    // Vsync mid-line after three pixels restarts the frame.
    applyStimulus(1'b0, 1'b1, 8'h00);
    sendLine(6, 8'h57);
    applyStimulus(1'b1, 1'b1, 8'h57);
    checkOutput("vsync_addr", 32'(addr), 32'h0);
    sendLine(4, 8'h57);
    idle(2);

    // Odd byte is discarded; next line starts with byte 1.
    sendLine(3, 8'h57);
    idle(2);
    applyStimulus(1'b1, 1'b0, 8'hE0);
    applyStimulus(1'b1, 1'b0, 8'h1F);
    checkOutput("partial_rgb", 32'(RGB332), 32'hE3);
    idle(2);

    // Random traffic with occasional Vsync.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(3, 0) != 0), ($urandom_range(63, 0) == 0), 8'($urandom));
    end

    // Reset asserted mid-line.
    sendLine(5, 8'($urandom));
    applyReset(3);
    sendLine(8, 8'($urandom));
    idle(2);

    // Fill the whole frame, then show capture stays frozen until Vsync.
    applyStimulus(1'b0, 1'b1, 8'h00);
    while (pixels < TOTAL) begin
      applyStimulus(($urandom_range(7, 0) != 0), 1'b0, 8'($urandom));
    end
    for (int i = 0; i < 60; i++) applyStimulus(1'($urandom), 1'b0, 8'($urandom));
    checkOutput("full_addr", 32'(addr), 32'(TOTAL - 1));
    applyStimulus(1'b0, 1'b1, 8'h00);
    sendLine(6, 8'h57);
    idle(2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
